dual_sync_ram_clr: RTL
======================

Name: dual_sync_ram_clr

Overview:
- Parametrised simple dual-port RAM: one write port and one read port on a single clock. It is the next generation of the team's 8x16 dual-port RAM.
- Adds per-byte write enables, a registered read with a valid strobe, out-of-range address protection, and a hardware clear sequencer.
- The clear sequencer zeroes every word after reset and reports a busy flag while it runs.
- Used as a generic storage element behind FIFOs and register banks in the datapath.

Parameters:
- WIDTH, 16, data word width in bits; must be a multiple of 8.
- DEPTH, 8, number of words; need not be a power of two.
- ADDR_W, $clog2(DEPTH) (min 1), address width; localparam derived from DEPTH, not overridable.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  reset; synchronous, active-high.
- we  in  1  write request.
- be  in  WIDTH/8  byte write enables; be[i] qualifies din[8i+7:8i].
- wr_addr  in  ADDR_W  write address.
- din  in  WIDTH  write data.
- re  in  1  read request.
- rd_addr  in  ADDR_W  read address.
- dout  out  WIDTH  registered read data.
- rd_valid  out  1  one-cycle strobe; dout updated this cycle.
- busy  out  1  clear sequencer active; port requests ignored.

Behaviour:
- Interface fixed: single clock clk; reset rst is synchronous and active-high.
- Reset (rst=1 at posedge):
  - dout=0, rd_valid=0, busy=1.
  - State is CLEAR and clr_ptr=0.
  - Memory contents are not touched while rst is held.
- States: CLEAR, RUN.
- CLEAR:
  - Each cycle with rst=0: mem[clr_ptr]<=0 and clr_ptr++.
  - When clr_ptr==DEPTH-1, that word is written, state goes to RUN and busy goes to 0 on the same edge.
  - The clear therefore takes exactly DEPTH cycles after rst deasserts.
  - we and re are ignored throughout CLEAR; rd_valid stays 0 and dout holds 0.
  - rst asserted mid-clear restarts the clear at clr_ptr=0.
- RUN, write:
  - At posedge with we=1, each byte i with be[i]=1 is written to mem[wr_addr].
  - be=0 gives a no-op write.
- RUN, read:
  - At posedge with re=1: dout<=mem[rd_addr] and rd_valid<=1.
  - Latency is 1 cycle.
  - With re=0: rd_valid<=0 and dout holds its last value.
- Out-of-range addresses (DEPTH not a power of two):
  - wr_addr>=DEPTH: the write is dropped.
  - rd_addr>=DEPTH with re=1: dout<=0 and rd_valid<=1.
- Simultaneous we and re, different addresses: both performed in the same cycle.
- Same address (read-during-write): see Optional Feature.
- Back-to-back reads are supported every cycle; there is no backpressure.

Optional Feature:
- Macro: DUAL_SYNC_RAM_BYPASS_EN.
- Defined (write-first):
  - A same-cycle read of wr_addr returns the merged word: bytes with be[i]=1 from din, the remaining bytes from old memory.
- Undefined (read-first):
  - The same read returns the old contents; the new data is visible on the next read.
- Out-of-range and busy rules are unchanged in both modes.

Decomposition:
- Package dual_sync_ram_pkg holds:
  - state typedef ram_state_t {CLEAR, RUN};
  - default constants WIDTH_DEF=16, DEPTH_DEF=8;
  - helper function be_merge(old, new, be) returning the byte-merged word.
- Sub-module dsram_clr_seq:
  - Contains the CLEAR/RUN FSM and clr_ptr counter.
  - Outputs busy, clr_we and clr_addr.
  - The top level muxes the clear writes onto the write port.

Test Plan:
- Reset then clear:
  - rst=1 for 2 cycles, then 0 -> busy=1 for exactly 8 cycles, then 0.
  - Reads of addresses 0..7 then return 0, with rd_valid high one cycle after each re.
- Basic access:
  - Write 16'hA5C3 to address 5 with be=2'b11, then re at address 5 next cycle -> dout=16'hA5C3 and rd_valid=1, both exactly one cycle after re.
- Byte enables:
  - Address 2 holds 16'h1234; write 16'hABCD with be=2'b10 -> read returns 16'hAB34.
- Read-during-write:
  - Address 3 holds 16'h0011; in the same cycle, write 16'hBEEF (be=2'b11) to address 3 and read address 3.
  - Macro defined: dout=16'hBEEF. Macro undefined: dout=16'h0011, then 16'hBEEF on the next read.
- Busy and mid-clear reset:
  - Assert rst after 3 clear cycles -> clear restarts; busy lasts 8 more cycles after deassert.
  - we/re asserted during busy -> no write, rd_valid=0.
- Out-of-range (DEPTH=6, WIDTH=32):
  - Write 32'hDEADBEEF to address 7 -> dropped.
  - Read address 7 -> dout=0, rd_valid=1.
  - Address 5 is still writable and readable.

Source files
------------

// File: rtl/dual_sync_ram_pkg.sv
// Shared types, defaults and helpers for the dual_sync_ram_clr storage block.
//   ram_state_t : clear-sequencer states (CLEAR while zeroing, RUN for normal access)
//   WIDTH_DEF / DEPTH_DEF : default word width and depth
//   be_merge()  : byte-lane merge of a new word over an old word
package dual_sync_ram_pkg;

  typedef enum logic [0:0] {CLEAR, RUN} ram_state_t;

  localparam int unsigned WIDTH_DEF = 16;
  localparam int unsigned DEPTH_DEF = 8;

  // be_merge works on a fixed maximum width so any WIDTH up to MaxWidth can share it;
  // callers zero-extend their operands and take the low WIDTH bits of the result.
  localparam int unsigned MaxWidth = 256;
  localparam int unsigned MaxBytes = MaxWidth / 8;

  function automatic logic [MaxWidth-1:0] be_merge(input logic [MaxWidth-1:0] old_word,
                                                   input logic [MaxWidth-1:0] new_word,
                                                   input logic [MaxBytes-1:0] be);
    logic [MaxWidth-1:0] merged;
    merged = old_word;
    for (int i = 0; i < int'(MaxBytes); i++) begin
      if (be[i]) begin
        merged[8*i +: 8] = new_word[8*i +: 8];
      end
    end
    return merged;
  endfunction

endpackage

// File: rtl/dsram_clr_seq.sv
// Clear sequencer for dual_sync_ram_clr.
// After reset it walks every address once, requesting a zero write per cycle, then
// parks in RUN. Reset mid-walk restarts from address 0.
// Ports:
//   clk      : clock, posedge
//   rst      : synchronous active-high reset
//   busy     : sequencer in CLEAR; the RAM ignores port requests
//   clr_we   : zero-write request for clr_addr this cycle
//   clr_addr : address being cleared
module dsram_clr_seq
  import dual_sync_ram_pkg::*;
#(
  parameter int unsigned DEPTH  = DEPTH_DEF,
  parameter int unsigned ADDR_W = 3
) (
  input  logic              clk,
  input  logic              rst,
  output logic              busy,
  output logic              clr_we,
  output logic [ADDR_W-1:0] clr_addr
);

  localparam logic [ADDR_W-1:0] LastPtr = ADDR_W'(DEPTH - 1);

  ram_state_t        state_q, state_d;
  logic [ADDR_W-1:0] clr_ptr_q, clr_ptr_d;

  always_comb begin
    state_d   = state_q;
    clr_ptr_d = clr_ptr_q;
    unique case (state_q)
      CLEAR: begin
        if (clr_ptr_q == LastPtr) begin
          state_d   = RUN;
          clr_ptr_d = '0;
        end else begin
          clr_ptr_d = clr_ptr_q + 1'b1;
        end
      end
      RUN: begin
        state_d = RUN;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= CLEAR;
      clr_ptr_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_ptr_q <= clr_ptr_d;
    end
  end

  assign busy     = (state_q == CLEAR);
  // Memory must stay untouched while reset is held.
  assign clr_we   = busy & ~rst;
  assign clr_addr = clr_ptr_q;

endmodule

// File: rtl/dual_sync_ram_clr.sv
// Simple dual-port RAM (one write, one read port, single clock) with per-byte write
// enables, registered read with valid strobe, out-of-range protection and a
// post-reset hardware clear.
// Build option: define DUAL_SYNC_RAM_BYPASS_EN for write-first read-during-write
// (read of the address being written returns the merged word); otherwise read-first.
// Ports:
//   clk, rst          : clock and synchronous active-high reset
//   we, be, wr_addr, din : write request, byte enables, address, data
//   re, rd_addr       : read request and address
//   dout, rd_valid    : registered read data and one-cycle valid strobe
//   busy              : clear in progress; we/re ignored
// WIDTH must be a non-zero multiple of 8 and no larger than MaxWidth.
module dual_sync_ram_clr
  import dual_sync_ram_pkg::*;
#(
  parameter  int unsigned WIDTH  = WIDTH_DEF,
  parameter  int unsigned DEPTH  = DEPTH_DEF,
  localparam int unsigned ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 we,
  input  logic [WIDTH/8-1:0]   be,
  input  logic [ADDR_W-1:0]    wr_addr,
  input  logic [WIDTH-1:0]     din,
  input  logic                 re,
  input  logic [ADDR_W-1:0]    rd_addr,
  output logic [WIDTH-1:0]     dout,
  output logic                 rd_valid,
  output logic                 busy
);

  localparam int unsigned       NumBytes = WIDTH / 8;
  localparam logic [ADDR_W:0]   DepthW   = (ADDR_W + 1)'(DEPTH);

`ifdef DUAL_SYNC_RAM_BYPASS_EN
  localparam bit Bypass = 1'b1;
`else
  localparam bit Bypass = 1'b0;
`endif

  logic [WIDTH-1:0] mem_q [DEPTH];

  logic              clr_we;
  logic [ADDR_W-1:0] clr_addr;

  logic              wr_in_range, rd_in_range, port_wr, rd_fire;
  logic [WIDTH-1:0]  old_word, merged, rd_word;
  logic [MaxWidth-1:0] old_ext, new_ext, merged_ext;
  logic [MaxBytes-1:0] be_ext;
  logic              unused_merged_ext;

  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [WIDTH-1:0]  mem_wdata;

  logic [WIDTH-1:0]  dout_q, dout_d;
  logic              rd_valid_q, rd_valid_d;

  dsram_clr_seq #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_clr_seq (
    .clk      (clk),
    .rst      (rst),
    .busy     (busy),
    .clr_we   (clr_we),
    .clr_addr (clr_addr)
  );

  // Write path: byte-merge the incoming data over the current word.
  always_comb begin
    wr_in_range = ({1'b0, wr_addr} < DepthW);
    old_word    = wr_in_range ? mem_q[wr_addr] : '0;
    old_ext     = '0;
    new_ext     = '0;
    be_ext      = '0;
    old_ext[WIDTH-1:0]   = old_word;
    new_ext[WIDTH-1:0]   = din;
    be_ext[NumBytes-1:0] = be;
    merged_ext  = be_merge(old_ext, new_ext, be_ext);
    merged      = merged_ext[WIDTH-1:0];
    port_wr     = we & ~busy & ~rst & wr_in_range & (|be);
  end

  // Upper lanes of the shared-width merge are intentionally discarded.
  assign unused_merged_ext = ^merged_ext;

  // The clear sequencer owns the write port while busy.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = wr_addr;
    mem_wdata = merged;
    if (clr_we) begin
      mem_we    = 1'b1;
      mem_waddr = clr_addr;
      mem_wdata = '0;
    end else if (port_wr) begin
      mem_we    = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[mem_waddr] <= mem_wdata;
    end
  end

  // Read path.
  always_comb begin
    rd_in_range = ({1'b0, rd_addr} < DepthW);
    rd_fire     = re & ~busy;
    if (!rd_in_range) begin
      rd_word = '0;
    end else if (Bypass && port_wr && (wr_addr == rd_addr)) begin
      rd_word = merged;
    end else begin
      rd_word = mem_q[rd_addr];
    end
    dout_d     = dout_q;
    rd_valid_d = 1'b0;
    if (rd_fire) begin
      dout_d     = rd_word;
      rd_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dout_q     <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      dout_q     <= dout_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  assign dout     = dout_q;
  assign rd_valid = rd_valid_q;

endmodule
